// File: rtl/game2048_pkg.sv
// game2048_pkg: shared direction encoding, receiver state encoding and one-hot decode helper
package game2048_pkg;
  typedef enum logic [1:0] {DIR_UP = 2'd0, DIR_DOWN = 2'd1, DIR_LEFT = 2'd2, DIR_RIGHT = 2'd3} dir_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_REQ = 2'd1, ST_WAIT_DONE = 2'd2} dir_rx_state_e;
  function automatic dir_e onehot_to_dir(input logic [3:0] p);
    return p[3] ? DIR_UP : p[2] ? DIR_DOWN : p[1] ? DIR_LEFT : DIR_RIGHT;
  endfunction
endpackage

// File: rtl/dir_cmd_fifo.sv
// dir_cmd_fifo: 2-deep, 2-bit command FIFO with synchronous push/pop/flush and async reset
module dir_cmd_fifo (
  input  logic       clock,
  input  logic       reset,
  input  logic       flush,
  input  logic       push,
  input  logic       pop,
  input  logic [1:0] din,
  output logic [1:0] dout,
  output logic       full,
  output logic       empty
);
  logic [1:0] mem [2];
  logic       wp, rp;
  logic [1:0] cnt;
  logic       do_push, do_pop;
  assign full    = cnt == 2'd2;
  assign empty   = cnt == 2'd0;
  assign dout    = mem[rp];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wp     <= 1'b0;
      rp     <= 1'b0;
      cnt    <= '0;
    end else if (flush) begin
      wp  <= 1'b0;
      rp  <= 1'b0;
      cnt <= '0;
    end else begin
      if (do_push) mem[wp] <= din;
      wp  <= wp ^ do_push;
      rp  <= rp ^ do_pop;
      cnt <= cnt + 2'(do_push) - 2'(do_pop);
    end
  end
endmodule

// File: rtl/direction_cmd_rx.sv
// direction_cmd_rx: validates one-hot direction pulses and issues one move at a time over req/ack/done.
// Define DIRECTION_CMD_RX_QUEUE_EN to buffer up to two commands in dir_cmd_fifo instead of dropping them.
module direction_cmd_rx
  import game2048_pkg::*;
#(
  parameter int DROP_CNT_W = 8,
  parameter int HOLDOFF    = 2
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            dir_pulse,
  input  logic                  game_active,
  output logic                  move_req,
  output logic [1:0]            move_dir,
  input  logic                  move_ack,
  input  logic                  move_done,
  output logic                  busy,
  output logic                  err_multi,
  output logic [DROP_CNT_W-1:0] drop_count
);
  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_REQ  = ST_REQ;
  localparam logic [1:0] S_WAIT = ST_WAIT_DONE;
  logic [1:0] state, state_nx;
  logic [3:0] hold, hold_nx;
  logic       onehot, multi, valid, idle_rdy, take, drop;
  logic [1:0] take_dir;
  assign onehot   = $onehot(dir_pulse);
  assign multi    = (dir_pulse != 4'd0) && !onehot;
  assign valid    = game_active && onehot;
  assign idle_rdy = (state == S_IDLE) && (hold == 4'd0);
`ifdef DIRECTION_CMD_RX_QUEUE_EN
  logic       q_full, q_empty;
  logic [1:0] q_head;
  dir_cmd_fifo u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (!game_active),
    .push  (valid),
    .pop   (take),
    .din   (onehot_to_dir(dir_pulse)),
    .dout  (q_head),
    .full  (q_full),
    .empty (q_empty)
  );
  assign take     = idle_rdy && game_active && !q_empty;
  assign take_dir = q_head;
  assign drop     = valid && q_full;
`else
  // With no holdoff, a pulse coinciding with move_done is taken straight into the next request.
  assign take     = valid && (idle_rdy || ((state == S_WAIT) && move_done && (HOLDOFF == 0)));
  assign take_dir = onehot_to_dir(dir_pulse);
  assign drop     = valid && !take;
`endif
  always_comb begin
    state_nx = take ? S_REQ :
               (state == S_REQ)  ? (!game_active ? S_IDLE : move_ack ? S_WAIT : S_REQ) :
               (state == S_WAIT) ? (move_done ? S_IDLE : S_WAIT) : state;
    hold_nx  = ((state == S_WAIT) && move_done) ? 4'(HOLDOFF) :
               ((state == S_IDLE) && (hold != 4'd0)) ? hold - 4'd1 : hold;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      hold       <= '0;
      move_dir   <= '0;
      err_multi  <= 1'b0;
      drop_count <= '0;
    end else begin
      state     <= state_nx;
      hold      <= hold_nx;
      err_multi <= game_active && multi;
      if (take) move_dir <= take_dir;
      if (drop && (drop_count != '1)) drop_count <= drop_count + 1'b1;
    end
  end
  assign move_req = state == S_REQ;
  assign busy     = (state != S_IDLE) || (hold != 4'd0);
endmodule

// File: tb/tb_direction_cmd_rx.sv
// tb_direction_cmd_rx: directed and random stimulus; a phase/queue reference model feeds a scoreboard
// of expected move directions that a negedge monitor pops on each new move_req.
module tb_direction_cmd_rx;
  localparam int HOLDOFF = 2;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] dir_pulse;
  logic       game_active, move_ack, move_done;
  logic       move_req, busy, err_multi;
  logic [1:0] move_dir;
  logic [7:0] drop_count;
  int n_vec = 0, n_err = 0;
  int m_phase = 0, m_hold = 0, m_drops = 0, m_err = 0;
  int m_q[$];
  int exp_q[$];
  bit prev_req = 1'b0;

  direction_cmd_rx #(.DROP_CNT_W(8), .HOLDOFF(HOLDOFF)) dut (
    .clock(clock), .reset(reset), .dir_pulse(dir_pulse), .game_active(game_active),
    .move_req(move_req), .move_dir(move_dir), .move_ack(move_ack), .move_done(move_done),
    .busy(busy), .err_multi(err_multi), .drop_count(drop_count)
  );

  always #10 clock = ~clock;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: engine phase (0 idle, 1 requesting, 2 engine busy), holdoff cycles left, pending queue.
  initial forever begin
    @(posedge clock or posedge reset);
    if (reset) begin
      m_phase = 0; m_hold = 0; m_drops = 0; m_err = 0;
      m_q.delete(); exp_q.delete();
    end else begin
      int c, d, nd, p0;
      bit vld, take, drop, full;
      c   = $countones(dir_pulse);
      vld = game_active && (c == 1);
      d   = (c == 1) ? 3 - $clog2(dir_pulse) : 0;
      nd  = d;
      p0  = m_phase;
`ifdef DIRECTION_CMD_RX_QUEUE_EN
      full = m_q.size() == 2;
      take = (p0 == 0) && (m_hold == 0) && game_active && (m_q.size() > 0);
      drop = vld && full;
      if (take) nd = m_q.pop_front();
      if (!game_active) m_q.delete();
      else if (vld && !full) m_q.push_back(d);
`else
      full = 1'b0;
      take = vld && (((p0 == 0) && (m_hold == 0)) || ((p0 == 2) && move_done && (HOLDOFF == 0)));
      drop = vld && !take;
`endif
      m_err = (game_active && c > 1) ? 1 : 0;
      if (drop && m_drops < 255) m_drops++;
      if (take) begin
        m_phase = 1;
        exp_q.push_back(nd);
      end else if (p0 == 0) begin
        if (m_hold > 0) m_hold--;
      end else if (p0 == 1) begin
        if (!game_active) m_phase = 0;
        else if (move_ack) m_phase = 2;
      end else if (move_done) begin
        m_phase = 0;
        m_hold  = HOLDOFF;
      end
    end
  end

  // Monitor: per-cycle status checks and scoreboard pop on each new request.
  initial forever begin
    @(negedge clock);
    if (reset) prev_req = 1'b0;
    else begin
      chk("req", int'(move_req), int'(m_phase == 1));
      chk("busy", int'(busy), int'(m_phase != 0 || m_hold != 0));
      chk("err_multi", int'(err_multi), m_err);
      chk("drop_count", int'(drop_count), m_drops);
      if (move_req && !prev_req) begin
        if (exp_q.size() == 0) chk("unexpected_req", 1, 0);
        else chk("move_dir", int'(move_dir), exp_q.pop_front());
      end
      prev_req = move_req;
    end
  end

  task automatic drive(input logic [3:0] p, input logic ga, input logic ack, input logic done);
    dir_pulse = p; game_active = ga; move_ack = ack; move_done = done;
    @(posedge clock);
    #1;
    dir_pulse = 4'd0; move_ack = 1'b0; move_done = 1'b0;
  endtask

  task automatic rnd_cycle();
    int r;
    logic [3:0] p;
    r = $urandom_range(0, 99);
    if (r < 50) p = 4'd0;
    else if (r < 85) p = 4'b0001 << $urandom_range(0, 3);
    else begin
      p = 4'($urandom_range(0, 15));
      while ($countones(p) < 2) p = 4'($urandom_range(0, 15));
    end
    drive(p, $urandom_range(0, 24) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; dir_pulse = 4'd0; game_active = 1'b0; move_ack = 1'b0; move_done = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst_req", int'(move_req), 0);
    chk("rst_dir", int'(move_dir), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_err", int'(err_multi), 0);
    chk("rst_drop", int'(drop_count), 0);
    reset = 1'b0;
`ifndef DIRECTION_CMD_RX_QUEUE_EN
    drive(4'b1000, 1, 0, 0);
    chk("t1_req", int'(move_req), 1);
    chk("t1_dir", int'(move_dir), 0);
    drive(4'b0000, 1, 1, 0);
    chk("t1_ack", int'(move_req), 0);
    drive(4'b0001, 1, 0, 0);
    chk("t2_drop", int'(drop_count), 1);
    chk("t2_noreq", int'(move_req), 0);
    drive(4'b0000, 1, 0, 1);
    drive(4'b0010, 1, 0, 0);
    drive(4'b0010, 1, 0, 0);
    chk("t2_holdoff_drop", int'(drop_count), 3);
    drive(4'b0010, 1, 0, 0);
    chk("t2_req", int'(move_req), 1);
    chk("t2_dir", int'(move_dir), 2);
    drive(4'b0000, 1, 1, 0);
    drive(4'b0000, 1, 0, 1);
    repeat (2) drive(4'b0000, 1, 0, 0);
    drive(4'b0110, 1, 0, 0);
    chk("t3_err", int'(err_multi), 1);
    chk("t3_noreq", int'(move_req), 0);
    chk("t3_drop", int'(drop_count), 3);
    drive(4'b0000, 1, 0, 0);
    chk("t3_err_clr", int'(err_multi), 0);
    drive(4'b0100, 1, 0, 0);
    chk("t4_req", int'(move_req), 1);
    drive(4'b0000, 0, 0, 0);
    chk("t4_abort", int'(move_req), 0);
    chk("t4_busy", int'(busy), 0);
    drive(4'b0001, 0, 0, 0);
    drive(4'b0110, 0, 0, 0);
    chk("t4_ignore_req", int'(move_req), 0);
    chk("t4_ignore_drop", int'(drop_count), 3);
    chk("t4_ignore_err", int'(err_multi), 0);
`else
    drive(4'b1000, 1, 0, 0);
    chk("t6_lat1", int'(move_req), 0);
    drive(4'b0000, 1, 0, 0);
    chk("t6_req", int'(move_req), 1);
    chk("t6_dir", int'(move_dir), 0);
    drive(4'b0000, 1, 1, 0);
    drive(4'b0001, 1, 0, 0);
    drive(4'b0010, 1, 0, 0);
    drive(4'b1000, 1, 0, 0);
    chk("t6_drop", int'(drop_count), 1);
    drive(4'b0000, 1, 0, 1);
    repeat (2) drive(4'b0000, 1, 0, 0);
    chk("t6_holdoff", int'(move_req), 0);
    drive(4'b0000, 1, 0, 0);
    chk("t6_req_right", int'(move_req), 1);
    chk("t6_dir_right", int'(move_dir), 3);
    drive(4'b0000, 1, 1, 0);
    drive(4'b0000, 1, 0, 1);
    repeat (3) drive(4'b0000, 1, 0, 0);
    chk("t6_req_left", int'(move_req), 1);
    chk("t6_dir_left", int'(move_dir), 2);
    drive(4'b0000, 1, 1, 0);
    drive(4'b0000, 1, 0, 1);
    repeat (3) drive(4'b0000, 1, 0, 0);
`endif
    repeat (2000) rnd_cycle();
    do_reset();
    drive(4'b0100, 1, 0, 0);
`ifdef DIRECTION_CMD_RX_QUEUE_EN
    drive(4'b0000, 1, 0, 0);
`endif
    chk("rst_mid_req_pre", int'(move_req), 1);
    #3 reset = 1'b1;
    #1;
    chk("rst_mid_req", int'(move_req), 0);
    chk("rst_mid_busy", int'(busy), 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    drive(4'b1000, 1, 0, 0);
`ifdef DIRECTION_CMD_RX_QUEUE_EN
    drive(4'b0000, 1, 0, 0);
`endif
    drive(4'b0000, 1, 1, 0);
    repeat (300) drive(4'b0001, 1, 0, 0);
    chk("t5_saturate", int'(drop_count), 255);
    drive(4'b0000, 1, 0, 1);
    repeat (4) drive(4'b0000, 1, 0, 0);
    chk("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
